// File: rtl/oddeven_count_arbiter_pkg.sv
// Shared encodings for the odd/even counter arbiter: FSM states, K mode values, counter width.
package oddeven_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic K_EVEN = 1'b0;
  localparam logic K_ODD  = 1'b1;
  localparam int   CNT_W  = 3;
endpackage

// File: rtl/oddeven_count_arbiter_if.sv
// Client/counter-side bundle of the arbiter; slave = arbiter, master = clients plus counter.
interface oddeven_count_arbiter_if #(parameter int CW = oddeven_pkg::CNT_W);
  logic [1:0]    REQ;
  logic [1:0]    GNT;
  logic [1:0]    DONE;
  logic          BUSY;
  logic          K;
  logic          CNT_CLR;
  logic          CNT_EN;
  logic [CW-1:0] CNT;
  logic          ERR;

  modport master (output REQ, CNT, input GNT, DONE, BUSY, K, CNT_CLR, CNT_EN, ERR);
  modport slave  (input REQ, CNT, output GNT, DONE, BUSY, K, CNT_CLR, CNT_EN, ERR);
endinterface

// File: rtl/oddeven_count_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot combinational pick, pointer remembers the last served index.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] gnt,
  output logic       idx
);
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd) last_d = upd_idx;
  end

  // last=1 out of reset so requester 0 takes the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign idx = gnt[1];
endmodule

// File: rtl/oddeven_count_arbiter.sv
// Arbitrates a shared odd/even counter: clear, settle, fixed burst, release.
// Build with OECA_STALL_CHECK_EN to flag a counter that fails to advance during a burst.
module oddeven_count_arbiter
  import oddeven_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int SETTLE    = 1,
  parameter int CW        = CNT_W
) (
  input logic                    CLK,
  input logic                    RST,
  oddeven_count_arbiter_if.slave bus
);
  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic       k_q, k_d;
  logic       clr_q, clr_d;
  logic       en_q, en_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] step_q, step_d;

  logic [1:0] arb_gnt;
  logic       arb_idx;
  logic       arb_upd;
  logic       held;

  rr_arb2 u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    (bus.REQ),
    .upd    (arb_upd),
    .upd_idx(k_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign held = |(bus.REQ & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    busy_d  = busy_q;
    k_d     = k_q;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    wait_d  = wait_q;
    step_d  = step_q;
    arb_upd = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          state_d = SETUP;
          gnt_d   = arb_gnt;
          k_d     = arb_idx ? K_ODD : K_EVEN;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
          wait_d  = 4'd0;
          step_d  = 4'd0;
        end
      end
      SETUP: begin
        if (!held) begin
          state_d = RELEASE;
          gnt_d   = 2'b00;
        end else if (wait_q == 4'(SETTLE)) begin
          state_d = RUN;
          en_d    = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RUN: begin
        step_d = step_q + 4'd1;
        // abort wins over a completing last step
        if (!held) begin
          state_d = RELEASE;
          gnt_d   = 2'b00;
        end else if (step_q == 4'(BURST_LEN - 1)) begin
          state_d = RELEASE;
          gnt_d   = 2'b00;
          done_d  = gnt_q;
        end else begin
          en_d = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        arb_upd = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      k_q     <= K_EVEN;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      wait_q  <= 4'd0;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      k_q     <= k_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      wait_q  <= wait_d;
      step_q  <= step_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.DONE    = done_q;
  assign bus.BUSY    = busy_q;
  assign bus.K       = k_q;
  assign bus.CNT_CLR = clr_q;
  assign bus.CNT_EN  = en_q;

`ifdef OECA_STALL_CHECK_EN
  logic [CW-1:0] prev_q, prev_d;
  logic          pvld_q, pvld_d;
  logic          err_q, err_d;

  // CNT in an enabled cycle is the result of the previous step; a repeat means no advance
  always_comb begin
    prev_d = prev_q;
    pvld_d = 1'b0;
    err_d  = err_q;
    if (clr_q) err_d = 1'b0;
    if (en_q) begin
      prev_d = bus.CNT;
      pvld_d = 1'b1;
      if (pvld_q && (bus.CNT == prev_q)) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q <= '0;
      pvld_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pvld_q <= pvld_d;
      err_q  <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  logic [CW-1:0] unused_cnt;
  assign unused_cnt = bus.CNT;
  assign bus.ERR    = 1'b0;
`endif
endmodule

// File: tb/tb_oddeven_count_arbiter.sv
// Bench: three DUTs (4/1, 1/0, 15/3 burst/settle) with behavioural counters, burst scoreboard.
`timescale 1ns/1ps
module tb_oddeven_count_arbiter;
  import oddeven_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic stall;
  always #5 CLK = ~CLK;

  oddeven_count_arbiter_if bus0();
  oddeven_count_arbiter_if bus1();
  oddeven_count_arbiter_if bus2();

  oddeven_count_arbiter #(.BURST_LEN(4),  .SETTLE(1), .CW(3)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  oddeven_count_arbiter #(.BURST_LEN(1),  .SETTLE(0), .CW(3)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  oddeven_count_arbiter #(.BURST_LEN(15), .SETTLE(3), .CW(3)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  logic [1:0] req [3];
  logic [2:0] cnt [3];
  assign bus0.REQ = req[0];
  assign bus1.REQ = req[1];
  assign bus2.REQ = req[2];
  assign bus0.CNT = cnt[0];
  assign bus1.CNT = cnt[1];
  assign bus2.CNT = cnt[2];

  // odd/even counters: clear to K, step by 2; stall freezes counter 0
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt[0] <= 3'd0; cnt[1] <= 3'd0; cnt[2] <= 3'd0;
    end else begin
      if (bus0.CNT_CLR) cnt[0] <= {2'b00, bus0.K};
      else if (bus0.CNT_EN && !stall) cnt[0] <= cnt[0] + 3'd2;
      if (bus1.CNT_CLR) cnt[1] <= {2'b00, bus1.K};
      else if (bus1.CNT_EN) cnt[1] <= cnt[1] + 3'd2;
      if (bus2.CNT_CLR) cnt[2] <= {2'b00, bus2.K};
      else if (bus2.CNT_EN) cnt[2] <= cnt[2] + 3'd2;
    end
  end

  logic [1:0] m_gnt [3];
  logic [1:0] m_done [3];
  logic       m_clr [3], m_en [3], m_busy [3], m_k [3], m_err [3];
  always_comb begin
    m_gnt[0] = bus0.GNT; m_done[0] = bus0.DONE; m_clr[0] = bus0.CNT_CLR; m_en[0] = bus0.CNT_EN;
    m_busy[0] = bus0.BUSY; m_k[0] = bus0.K; m_err[0] = bus0.ERR;
    m_gnt[1] = bus1.GNT; m_done[1] = bus1.DONE; m_clr[1] = bus1.CNT_CLR; m_en[1] = bus1.CNT_EN;
    m_busy[1] = bus1.BUSY; m_k[1] = bus1.K; m_err[1] = bus1.ERR;
    m_gnt[2] = bus2.GNT; m_done[2] = bus2.DONE; m_clr[2] = bus2.CNT_CLR; m_en[2] = bus2.CNT_EN;
    m_busy[2] = bus2.BUSY; m_k[2] = bus2.K; m_err[2] = bus2.ERR;
  end

  typedef struct {
    int         inst;
    logic [1:0] gnt;
    logic       k;
    int         en;
    int         gap;
    logic [1:0] done;
    logic       err;
  } rec_t;

  typedef struct {
    int         inst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       k;
    int         en;
    int         gap;
  } vec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_cnt = 0;
  int   mon_en0 = 0;
  int   target = 0;

  bit         inb [3], seen [3], kok [3], bchk [3];
  int         en_n [3], gap_n [3];
  logic       kref [3];
  logic [1:0] gref [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [1:0] gnt, input logic k, input int en,
                      input int gap, input logic [1:0] done, input logic err);
    rec_t r;
    r.inst = inst; r.gnt = gnt; r.k = k; r.en = en; r.gap = gap; r.done = done; r.err = err;
    exp_q.push_back(r);
  endtask

  // burst monitor: one record per grant, closed in the RELEASE cycle
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (RST) begin
        inb[i] = 0; bchk[i] = 0; en_n[i] = 0;
      end else begin
        if (bchk[i]) begin
          chk($sformatf("busy_drop%0d", i), 32'(m_busy[i]), 32'd0);
          bchk[i] = 0;
        end
        if (m_clr[i]) begin
          inb[i] = 1; en_n[i] = 0; gap_n[i] = 0; seen[i] = 0; kok[i] = 1;
          kref[i] = m_k[i]; gref[i] = m_gnt[i];
        end else if (inb[i]) begin
          if (m_en[i]) begin
            en_n[i]++; seen[i] = 1;
            if (m_k[i] !== kref[i] || m_gnt[i] !== gref[i]) kok[i] = 0;
          end else if (!seen[i] && m_gnt[i] != 2'b00) begin
            gap_n[i]++;
          end
          if (m_gnt[i] == 2'b00) begin
            inb[i] = 0; bchk[i] = 1;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_burst inst=%0d gnt=%b", i, gref[i]);
            end else begin
              rec_t e;
              e = exp_q.pop_front();
              chk("inst", i, e.inst);
              chk($sformatf("gnt%0d", i), 32'(gref[i]), 32'(e.gnt));
              chk($sformatf("k%0d", i), 32'(kref[i]), 32'(e.k));
              chk($sformatf("en_cycles%0d", i), en_n[i], e.en);
              chk($sformatf("settle_gap%0d", i), gap_n[i], e.gap);
              chk($sformatf("done%0d", i), 32'(m_done[i]), 32'(e.done));
              chk($sformatf("err%0d", i), 32'(m_err[i]), 32'(e.err));
              chk($sformatf("k_gnt_stable%0d", i), 32'(kok[i]), 32'd1);
            end
            mon_cnt++;
          end
        end
      end
    end
    mon_en0 = en_n[0];
  end

  task automatic wait_mon(input int tgt);
    int b = 0;
    while (mon_cnt < tgt && b < 300) begin
      @(negedge CLK); #1; b++;
    end
    chk("burst_arrived", 32'(mon_cnt >= tgt), 32'd1);
  endtask

  task automatic wait_en(input int n);
    int b = 0;
    while (!(mon_en0 == n && bus0.CNT_EN) && b < 100) begin
      @(negedge CLK); #1; b++;
    end
    chk("en_reached", 32'(mon_en0 == n), 32'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 32'({bus0.GNT, bus0.DONE, bus0.BUSY, bus0.K, bus0.CNT_CLR, bus0.CNT_EN, bus0.ERR}), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1 chk_zero("reset_outputs");
    @(negedge CLK); #1 RST = 1'b0;
  endtask

  vec_t vt [7];

  initial begin
    vt[0] = '{0, 2'b01, 2'b01, 1'b0, 4,  1};
    vt[1] = '{0, 2'b10, 2'b10, 1'b1, 4,  1};
    vt[2] = '{0, 2'b11, 2'b01, 1'b0, 4,  1};
    vt[3] = '{1, 2'b01, 2'b01, 1'b0, 1,  0};
    vt[4] = '{1, 2'b10, 2'b10, 1'b1, 1,  0};
    vt[5] = '{2, 2'b10, 2'b10, 1'b1, 15, 3};
    vt[6] = '{2, 2'b01, 2'b01, 1'b0, 15, 3};

    stall = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 2'b00;
    RST = 1'b1;
    #2 chk_zero("reset_initial");
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;

    for (int v = 0; v < 7; v++) begin
      push(vt[v].inst, vt[v].gnt, vt[v].k, vt[v].en, vt[v].gap, vt[v].gnt, 1'b0);
      req[vt[v].inst] = vt[v].req;
      target++;
      wait_mon(target);
      req[vt[v].inst] = 2'b00;
      repeat (3) @(negedge CLK);
      #1;
    end

    // contention from reset alternates starting with requester 0
    do_reset();
    for (int j = 0; j < 4; j++)
      push(0, (j % 2 == 0) ? 2'b01 : 2'b10, (j % 2 == 1), 4, 1, (j % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
    req[0] = 2'b11;
    target += 4;
    wait_mon(target);
    req[0] = 2'b00;
    repeat (3) @(negedge CLK);
    #1;

    // serve 0, abort 1 after two steps, then the tie must go to 0
    push(0, 2'b01, 1'b0, 4, 1, 2'b01, 1'b0);
    req[0] = 2'b01; target++; wait_mon(target); req[0] = 2'b00;
    repeat (3) @(negedge CLK);
    #1;
    push(0, 2'b10, 1'b1, 2, 1, 2'b00, 1'b0);
    req[0] = 2'b10;
    wait_en(2);
    req[0] = 2'b00;
    target++; wait_mon(target);
    repeat (3) @(negedge CLK);
    #1;
    push(0, 2'b01, 1'b0, 4, 1, 2'b01, 1'b0);
    req[0] = 2'b11; target++; wait_mon(target); req[0] = 2'b00;
    repeat (3) @(negedge CLK);
    #1;

    // reset on the third enable, then a clean burst
    req[0] = 2'b10;
    wait_en(3);
    RST = 1'b1;
    #1 chk_zero("reset_mid_run");
    @(negedge CLK); #1 RST = 1'b0;
    push(0, 2'b10, 1'b1, 4, 1, 2'b10, 1'b0);
    target++; wait_mon(target); req[0] = 2'b00;
    repeat (3) @(negedge CLK);
    #1;

`ifdef OECA_STALL_CHECK_EN
    stall = 1'b1;
    push(0, 2'b01, 1'b0, 4, 1, 2'b01, 1'b1);
    req[0] = 2'b01; target++; wait_mon(target); req[0] = 2'b00;
    repeat (3) @(negedge CLK);
    #1 chk("err_sticky_idle", 32'(bus0.ERR), 32'd1);
    stall = 1'b0;
    push(0, 2'b01, 1'b0, 4, 1, 2'b01, 1'b0);
    req[0] = 2'b01; target++; wait_mon(target); req[0] = 2'b00;
    repeat (3) @(negedge CLK);
    #1;
`else
    stall = 1'b1;
    push(0, 2'b01, 1'b0, 4, 1, 2'b01, 1'b0);
    req[0] = 2'b01; target++; wait_mon(target); req[0] = 2'b00;
    repeat (3) @(negedge CLK);
    #1 chk("err_tied_low", 32'(bus0.ERR), 32'd0);
    stall = 1'b0;
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
